// File: rtl/sram_ctrl_pkg.sv
// Shared types and defaults for the SRAM access controller.
// Imported by the arbiter and the controller top.
package sram_ctrl_pkg;

  localparam int SRAM_ADDR_W = 7;
  localparam int SRAM_DATA_W = 8;
  localparam int SRAM_ID_W   = 3;
  localparam int SRAM_DEPTH  = 2 ** SRAM_ADDR_W;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } ctrl_state_e;

  typedef struct packed {
    logic                   we;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_DATA_W-1:0] wdata;
    logic [SRAM_ID_W-1:0]   id;
  } cmd_t;

endpackage

// File: rtl/sram_access_ctrl_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the pointer.
// The pointer moves to the granted index only when a grant is taken.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_any
);

  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   ptr_d;
  logic [NUM_REQ-1:0] gnt_c;
  logic [IDX_W-1:0]   idx_c;
  logic               found;
  int                 cand;

  always_comb begin
    gnt_c = '0;
    idx_c = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req[IDX_W'(cand)]) begin
        found                = 1'b1;
        gnt_c[IDX_W'(cand)]  = 1'b1;
        idx_c                = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (en && found) ptr_d = idx_c;
  end

  assign gnt     = en ? gnt_c : '0;
  assign gnt_idx = idx_c;
  assign gnt_any = en && found;

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= IDX_W'(NUM_REQ - 1);
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sram_access_ctrl.sv
// Shares one single-port SRAM between requesters: scrubs to zero after
// reset, then issues one command per cycle with a 3-cycle read response.
module sram_access_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = SRAM_ADDR_W,
  parameter int DATA_W  = SRAM_DATA_W,
  parameter int ID_W    = SRAM_ID_W
) (
  input  logic                      sram_clk,
  input  logic                      sram_ares_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      init_done,
  output logic                      wr_enable,
  output logic                      rd_enable,
  output logic [ADDR_W-1:0]         ram_index,
  output logic [DATA_W-1:0]         sram_data_in,
  input  logic [DATA_W-1:0]         sram_data_out
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  ctrl_state_e       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [ID_W-1:0]   s1_id_q, s1_id_d;
  logic              s2_rd_q, s2_rd_d;
  logic [ID_W-1:0]   s2_id_q, s2_id_d;
  logic              rsp_v_q, rsp_v_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_rd_q, rsp_rd_d;

  logic              run;
  logic              acc;
  logic [IDX_W-1:0]  gnt_idx;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign run = (state_q == RUN);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .clk     (sram_clk),
    .rst_n   (sram_ares_n),
    .en      (run),
    .req     (req_valid),
    .gnt     (req_ready),
    .gnt_idx (gnt_idx),
    .gnt_any (acc)
  );

  assign sel_we    = req_we[gnt_idx];
  assign sel_addr  = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
  assign sel_wdata = req_wdata[int'(gnt_idx)*DATA_W +: DATA_W];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    idx_d   = idx_q;
    din_d   = din_q;
    s1_id_d = s1_id_q;
    unique case (state_q)
      INIT: begin
        // Leave once the last index is on the pins this cycle.
        if (wr_q && idx_q == {ADDR_W{1'b1}}) begin
          state_d = RUN;
          done_d  = 1'b1;
        end else begin
          wr_d  = 1'b1;
          idx_d = cnt_q;
          din_d = '0;
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (acc) begin
          wr_d    = sel_we;
          rd_d    = !sel_we;
          idx_d   = sel_addr;
          s1_id_d = ID_W'(gnt_idx);
          if (sel_we) din_d = sel_wdata;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    s2_rd_d  = rd_q;
    s2_id_d  = s1_id_q;
    rsp_v_d  = s2_rd_q;
    rsp_id_d = rsp_id_q;
    rsp_rd_d = rsp_rd_q;
    if (s2_rd_q) begin
      rsp_id_d = s2_id_q;
      rsp_rd_d = sram_data_out;
    end
  end

  always_ff @(posedge sram_clk) begin
    if (!sram_ares_n) begin
      state_q  <= INIT;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      idx_q    <= '0;
      din_q    <= '0;
      s1_id_q  <= '0;
      s2_rd_q  <= 1'b0;
      s2_id_q  <= '0;
      rsp_v_q  <= 1'b0;
      rsp_id_q <= '0;
      rsp_rd_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      idx_q    <= idx_d;
      din_q    <= din_d;
      s1_id_q  <= s1_id_d;
      s2_rd_q  <= s2_rd_d;
      s2_id_q  <= s2_id_d;
      rsp_v_q  <= rsp_v_d;
      rsp_id_q <= rsp_id_d;
      rsp_rd_q <= rsp_rd_d;
    end
  end

  assign init_done    = done_q;
  assign wr_enable    = wr_q;
  assign rd_enable    = rd_q;
  assign ram_index    = idx_q;
  assign sram_data_in = din_q;
  assign rsp_valid    = rsp_v_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_rdata    = rsp_rd_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl with a behavioural 128x8 SRAM.
// Vector table per cycle plus hand sequences for scrub and reset.
module tb_sram_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_we;
  logic [13:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [2:0]  rsp_id;
  logic [7:0]  rsp_rdata;
  logic        init_done;
  logic        wr_enable;
  logic        rd_enable;
  logic [6:0]  ram_index;
  logic [7:0]  sram_data_in;
  logic [7:0]  sram_data_out = 8'h00;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [128] = '{default: 8'hFF};

  sram_access_ctrl dut (
    .sram_clk      (clk),
    .sram_ares_n   (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_id        (rsp_id),
    .rsp_rdata     (rsp_rdata),
    .init_done     (init_done),
    .wr_enable     (wr_enable),
    .rd_enable     (rd_enable),
    .ram_index     (ram_index),
    .sram_data_in  (sram_data_in),
    .sram_data_out (sram_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_enable) mem[ram_index] <= sram_data_in;
    if (rd_enable) sram_data_out <= mem[ram_index];
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) chk("no_overlap", 32'(wr_enable && rd_enable), 0);

  task automatic drive(input logic [1:0] v, input logic [1:0] we,
                       input logic [6:0] a0, input logic [7:0] d0,
                       input logic [6:0] a1, input logic [7:0] d1);
    req_valid = v;
    req_we    = we;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
  endtask

  task automatic scrub(input logic [1:0] rdy_after);
    for (int i = 0; i < 128; i++) begin
      @(negedge clk); #1;
      chk($sformatf("scrub%0d", i),
          32'({wr_enable, rd_enable, ram_index, sram_data_in,
               init_done, rsp_valid, req_ready}),
          32'({1'b1, 1'b0, 7'(i), 8'h00, 1'b0, 1'b0, 2'b00}));
    end
    @(negedge clk); #1;
    chk("init_done_rise", 32'(init_done), 1);
    chk("idle_after_scrub", 32'({wr_enable, rd_enable}), 0);
    chk("first_run_ready", 32'(req_ready), 32'(rdy_after));
  endtask

  typedef struct {
    logic [1:0] v;
    logic [1:0] we;
    logic [6:0] a0;
    logic [7:0] d0;
    logic [6:0] a1;
    logic [7:0] d1;
    logic [1:0] rdy;
    logic       rv;
    logic [2:0] id;
    logic [7:0] rd;
  } vec_t;

  vec_t tbl [20];

  function automatic vec_t mk(input logic [1:0] v, input logic [1:0] we,
                              input logic [6:0] a0, input logic [7:0] d0,
                              input logic [6:0] a1, input logic [1:0] rdy,
                              input logic rv, input logic [2:0] id,
                              input logic [7:0] rd);
    vec_t r;
    r.v = v; r.we = we; r.a0 = a0; r.d0 = d0; r.a1 = a1; r.d1 = 8'h00;
    r.rdy = rdy; r.rv = rv; r.id = id; r.rd = rd;
    return r;
  endfunction

  initial begin
    // write A5@12, read it back 3 cycles later
    tbl[0]  = mk(2'b01, 2'b01, 7'h12, 8'hA5, 7'h00, 2'b01, 0, 0, 8'h00);
    tbl[1]  = mk(2'b01, 2'b00, 7'h12, 8'h00, 7'h00, 2'b01, 0, 0, 8'h00);
    tbl[2]  = mk(2'b00, 2'b00, 7'h00, 8'h00, 7'h00, 2'b00, 0, 0, 8'h00);
    tbl[3]  = mk(2'b00, 2'b00, 7'h00, 8'h00, 7'h00, 2'b00, 0, 0, 8'h00);
    tbl[4]  = mk(2'b00, 2'b00, 7'h00, 8'h00, 7'h00, 2'b00, 1, 0, 8'hA5);
    // req1 alone, then both contend and alternate 0,1,0,1...
    tbl[5]  = mk(2'b10, 2'b00, 7'h12, 8'h00, 7'h00, 2'b10, 0, 0, 8'h00);
    tbl[6]  = mk(2'b11, 2'b00, 7'h12, 8'h00, 7'h00, 2'b01, 0, 0, 8'h00);
    tbl[7]  = mk(2'b11, 2'b00, 7'h12, 8'h00, 7'h00, 2'b10, 0, 0, 8'h00);
    tbl[8]  = mk(2'b11, 2'b00, 7'h12, 8'h00, 7'h00, 2'b01, 1, 1, 8'h00);
    tbl[9]  = mk(2'b11, 2'b00, 7'h12, 8'h00, 7'h00, 2'b10, 1, 0, 8'hA5);
    tbl[10] = mk(2'b11, 2'b00, 7'h12, 8'h00, 7'h00, 2'b01, 1, 1, 8'h00);
    tbl[11] = mk(2'b11, 2'b00, 7'h12, 8'h00, 7'h00, 2'b10, 1, 0, 8'hA5);
    tbl[12] = mk(2'b11, 2'b00, 7'h12, 8'h00, 7'h00, 2'b01, 1, 1, 8'h00);
    tbl[13] = mk(2'b11, 2'b00, 7'h12, 8'h00, 7'h00, 2'b10, 1, 0, 8'hA5);
    // req0 writes 3C@7F, req1 reads 7F on the next cycle
    tbl[14] = mk(2'b01, 2'b01, 7'h7F, 8'h3C, 7'h00, 2'b01, 1, 1, 8'h00);
    tbl[15] = mk(2'b10, 2'b00, 7'h12, 8'h00, 7'h7F, 2'b10, 1, 0, 8'hA5);
    tbl[16] = mk(2'b00, 2'b00, 7'h00, 8'h00, 7'h00, 2'b00, 1, 1, 8'h00);
    tbl[17] = mk(2'b00, 2'b00, 7'h00, 8'h00, 7'h00, 2'b00, 0, 0, 8'h00);
    tbl[18] = mk(2'b00, 2'b00, 7'h00, 8'h00, 7'h00, 2'b00, 1, 1, 8'h3C);
    tbl[19] = mk(2'b00, 2'b00, 7'h00, 8'h00, 7'h00, 2'b00, 0, 0, 8'h00);

    rst_n = 1'b0;
    drive(2'b00, 2'b00, 7'h00, 8'h00, 7'h00, 8'h00);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_outputs",
        32'({wr_enable, rd_enable, ram_index, sram_data_in, init_done}), 0);
    chk("rst_rsp", 32'({rsp_valid, rsp_id, rsp_rdata}), 0);
    chk("rst_ready", 32'(req_ready), 0);

    rst_n = 1'b1;
    scrub(2'b00);

    foreach (tbl[r]) begin
      @(negedge clk);
      drive(tbl[r].v, tbl[r].we, tbl[r].a0, tbl[r].d0, tbl[r].a1, tbl[r].d1);
      #1;
      chk($sformatf("ready_r%0d", r), 32'(req_ready), 32'(tbl[r].rdy));
      chk($sformatf("rsp_valid_r%0d", r), 32'(rsp_valid), 32'(tbl[r].rv));
      if (tbl[r].rv) begin
        chk($sformatf("rsp_id_r%0d", r), 32'(rsp_id), 32'(tbl[r].id));
        chk($sformatf("rsp_rdata_r%0d", r), 32'(rsp_rdata), 32'(tbl[r].rd));
      end
    end

    // read accepted, reset lands before its response
    @(negedge clk);
    drive(2'b01, 2'b00, 7'h12, 8'h00, 7'h00, 8'h00);
    #1;
    chk("pre_rst_ready", 32'(req_ready), 32'(2'b01));
    @(negedge clk);
    rst_n = 1'b0;
    drive(2'b00, 2'b00, 7'h00, 8'h00, 7'h00, 8'h00);
    @(negedge clk); #1;
    chk("mid_rst_enables", 32'({wr_enable, rd_enable}), 0);
    chk("mid_rst_rsp", 32'(rsp_valid), 0);
    chk("mid_rst_done", 32'(init_done), 0);
    rst_n = 1'b1;
    // req1 write waits through the whole scrub
    drive(2'b10, 2'b10, 7'h00, 8'h00, 7'h05, 8'h77);
    scrub(2'b10);

    @(negedge clk);
    drive(2'b01, 2'b00, 7'h05, 8'h00, 7'h00, 8'h00);
    #1;
    chk("rd05_ready", 32'(req_ready), 32'(2'b01));
    @(negedge clk);
    drive(2'b01, 2'b00, 7'h12, 8'h00, 7'h00, 8'h00);
    #1;
    chk("rd12_ready", 32'(req_ready), 32'(2'b01));
    @(negedge clk);
    drive(2'b00, 2'b00, 7'h00, 8'h00, 7'h00, 8'h00);
    #1;
    chk("rsp_quiet", 32'(rsp_valid), 0);
    @(negedge clk); #1;
    chk("rd05_rsp", 32'({rsp_valid, rsp_id, rsp_rdata}),
        32'({1'b1, 3'd0, 8'h77}));
    @(negedge clk); #1;
    chk("rd12_rsp", 32'({rsp_valid, rsp_id, rsp_rdata}),
        32'({1'b1, 3'd0, 8'h00}));
    @(negedge clk); #1;
    chk("rsp_hold", 32'({rsp_valid, rsp_rdata}), 32'({1'b0, 8'h00}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
